control_sequencer: RTL

Hardwired control unit for the Mini SRC datapath. It fetches and executes one instruction at a time by driving the register in/out strobes, the general-register select (Gra/Grb/Grc) lines, the ALU opcode and the memory read request. It also handles a memory-ready handshake on instruction fetch, retires register-format ALU, mul/div, nop and halt instructions, and flags illegal opcodes and fetch timeouts. It sits beside the datapath and is the only source of its control strobes.

---
 rtl/control_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini SRC control unit.
// Fetches one instruction at a time (with a bounded memory-ready wait), then
// sequences register-format ALU, nop, halt and optional mul/div instructions.
// Optional feature macro: CONTROL_SEQUENCER_MULDIV_EN enables the mul/div path
// (EXEC6, lo_in/hi_in). Without it, mul/div opcodes are treated as illegal.

module control_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        z_in,
    output logic        zlow_out,
    output logic        zhigh_out,
    output logic        pc_in,
    output logic        mem_read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        lo_in,
    output logic        hi_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic [4:0]  alu_op,
    output logic        running,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_EXEC3,
        S_EXEC4,
        S_EXEC5,
        S_EXEC6,
        S_HALT
    } state_e;

    localparam logic [4:0] OP_ALU_MAX = 5'b01000;
    localparam logic [4:0] OP_MUL     = 5'b01111;
    localparam logic [4:0] OP_DIV     = 5'b10000;
    localparam logic [4:0] OP_NOP     = 5'b11001;
    localparam logic [4:0] OP_HALT    = 5'b11010;

    // Value of the wait counter during the last FETCH1 cycle allowed before timeout.
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;

    logic [4:0]  opcode;
    logic        op_alu;
    logic        op_muldiv;
    logic        op_nop;
    logic        op_halt;
    logic        unused_ir_bits;

    assign opcode         = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];

    assign op_alu  = (opcode <= OP_ALU_MAX);
    assign op_nop  = (opcode == OP_NOP);
    assign op_halt = (opcode == OP_HALT);
`ifdef CONTROL_SEQUENCER_MULDIV_EN
    assign op_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
    assign op_muldiv = 1'b0;
`endif

    // State register, fetch wait counter, sticky flags and retire counter.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic: sequencing, fetch timeout, decode and retirement.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retire    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH0;
            end
            S_FETCH0: begin
                state_d = S_FETCH1;
                wait_d  = '0;
            end
            S_FETCH1: begin
                // Data arriving on the timeout edge still wins.
                if (mem_ready) begin
                    state_d = S_FETCH2;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_FETCH2: begin
                state_d = S_EXEC3;
            end
            S_EXEC3: begin
                if (op_alu || op_muldiv) begin
                    state_d = S_EXEC4;
                end else if (op_nop) begin
                    retire  = 1'b1;
                    state_d = S_FETCH0;
                end else if (op_halt) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH0;
                end
            end
            S_EXEC4: begin
                state_d = S_EXEC5;
            end
            S_EXEC5: begin
                if (op_muldiv) begin
                    state_d = S_EXEC6;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH0;
                end
            end
            S_EXEC6: begin
                retire  = 1'b1;
                state_d = S_FETCH0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating count of completed instructions.
    always_comb begin
        retired_d = retired_q;
        if (retire && (retired_q != 32'hFFFF_FFFF)) retired_d = retired_q + 32'd1;
    end

    // Moore strobe decode of the state register.
    always_comb begin
        pc_out    = 1'b0;
        mar_in    = 1'b0;
        inc_pc    = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        pc_in     = 1'b0;
        mem_read  = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        gra       = 1'b0;
        grb       = 1'b0;
        grc       = 1'b0;
        r_in      = 1'b0;
        r_out     = 1'b0;
        alu_op    = 5'd0;

        case (state_q)
            S_FETCH0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_FETCH1: begin
                zlow_out = 1'b1;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
                // Only the first wait cycle loads PC, so it advances once.
                pc_in    = (wait_q == 8'd0);
            end
            S_FETCH2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_EXEC3: begin
                if (op_alu || op_muldiv) begin
                    grb   = 1'b1;
                    r_out = 1'b1;
                    y_in  = 1'b1;
                end
            end
            S_EXEC4: begin
                grc    = 1'b1;
                r_out  = 1'b1;
                z_in   = 1'b1;
                alu_op = opcode;
            end
            S_EXEC5: begin
                zlow_out = 1'b1;
                if (op_muldiv) begin
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                    lo_in = 1'b1;
`endif
                end else begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                end
            end
            S_EXEC6: begin
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    assign running = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule
